mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the CPU's single-port memory between the instruction-fetch requester and the load/store unit.
//  Arbitrates, drives the memory port for one access at a time and returns read data to the owner.
//  Sits between cpu_fetch / the memory stage and the unified instruction/data RAM.
//  At most one transaction is outstanding.
// PARAMETERS
//  ADDR_W           32  address width, all address ports
//  DATA_W           32  data width; byte strobes are DATA_W/8 bits wide
//  MEM_LAT           2  cycles from the mem_en cycle to valid mem_rdata (legal range 1..7)
//  MAX_DATA_STREAK   3  consecutive data grants allowed while if_req is pending (>=1)
// PORTS
//  clk        in   1         clock, rising edge
//  reset      in   1         asynchronous, active-high
//  if_req     in   1         fetch read request; held with if_addr until if_gnt
//  if_addr    in   ADDR_W    fetch address
//  if_gnt     out  1         one-cycle grant pulse to fetch
//  if_rvalid  out  1         one-cycle pulse: if_rdata is valid
//  if_rdata   out  DATA_W    fetch read data
//  d_req      in   1         data request; held with d_we, d_addr, d_wdata, d_wstrb until d_gnt
//  d_we       in   1         1 = write, 0 = read
//  d_addr     in   ADDR_W    data address
//  d_wdata    in   DATA_W    write data
//  d_wstrb    in   DATA_W/8  write byte enables
//  d_gnt      out  1         one-cycle grant pulse to the data requester
//  d_rvalid   out  1         one-cycle pulse: d_rdata is valid (reads only)
//  d_rdata    out  DATA_W    load data
//  mem_en     out  1         memory access strobe
//  mem_we     out  DATA_W/8  byte write enables; 0 = read
//  mem_addr   out  ADDR_W    memory address, passed through unaligned
//  mem_wdata  out  DATA_W    memory write data
//  mem_rdata  in   DATA_W    memory read data
//  busy       out  1         high whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, streak=0, owner=fetch. All outputs read 0. An in-flight read is dropped and no rvalid is issued.
//  FSM states:
//   IDLE: sample requests at the clock edge. If any request is present, latch the winner's fields and go to ACCESS.
//   ACCESS (1 cycle): mem_en=1 and the latched fields drive the memory; the owner's gnt=1.
//    A read goes to WAIT. A write goes to IDLE.
//   WAIT: counter runs 1..MEM_LAT. In the cycle where cnt==MEM_LAT, the owner's rvalid=1 and rdata=mem_rdata.
//    The next edge goes to IDLE.
//  Latency: request seen in IDLE -> gnt on the next cycle (A) -> read data in cycle A+MEM_LAT.
//   A read occupies the port for 2+MEM_LAT cycles including IDLE; a write occupies it for 2 cycles.
//  Handshake:
//   The requester holds req and its fields stable through its gnt cycle.
//   req is ignored outside IDLE.
//   The requester may present its next request in the cycle after gnt.
//  Arbitration: data wins over fetch, except when streak==MAX_DATA_STREAK and if_req=1; then fetch wins.
//   streak increments on a data grant made while if_req=1.
//   streak clears on any fetch grant and on any data grant made with if_req=0.
//  Write: mem_we=d_wstrb. d_we=1 with d_wstrb=0 is a no-op access: mem_en=1, mem_we=0, no WAIT, no rvalid.
//  Data path: rdata outputs are 0 whenever their rvalid is low. mem_we, mem_addr and mem_wdata are 0 when mem_en=0.
//  Reset mid-WAIT: returns to IDLE immediately. A request still held after reset is re-arbitrated normally.
// TESTING (MEM_LAT=2, MAX_DATA_STREAK=3)
//  if_req, if_addr=0x10 with mem_rdata=0x00000013 at A+2 -> if_gnt at A, mem_en/mem_addr=0x10 at A,
//   if_rvalid with if_rdata=0x13 at A+2, busy low at A+3.
//  if_req and d_req (read, 0x100) rise together -> d_gnt first; if_gnt 4 cycles later; no cycle with both gnts high.
//  d_req held continuously (reads) with if_req=1 -> grants go D,D,D,F,D,D,D,F...; if_gnt within 4 data grants.
//  Write d_addr=0x20, d_wdata=0xDEADBEEF, d_wstrb=4'b0011 -> mem_we=0011 for 1 cycle; no d_rvalid; IDLE after 2 cycles.
//  reset asserted in WAIT cnt=1 -> outputs 0 asynchronously, no rvalid; after release, if_req gets gnt 1 cycle later.
//  d_we=1, d_wstrb=0 -> mem_en pulse with mem_we=0, d_gnt, no d_rvalid, busy 1 cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store, one access in flight
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MEM_LAT         = 2,
    parameter int MAX_DATA_STREAK = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int BW = DATA_W / 8;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
    state_t state, state_nxt;
    logic own_d, is_wr, pick_d, done;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BW-1:0] wstrb_q;
    logic [2:0] cnt;
    logic [SW-1:0] streak;
    // fetch only overtakes data once the data side has used up its streak allowance
    assign pick_d = d_req && !(if_req && streak == SW'(MAX_DATA_STREAK));
    assign done = state == WAIT && cnt == 3'(MEM_LAT);
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (if_req || d_req) ? ACCESS : IDLE;
            ACCESS:  state_nxt = is_wr ? IDLE : WAIT;
            WAIT:    state_nxt = done ? IDLE : WAIT;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            own_d   <= 1'b0;
            is_wr   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt     <= 3'd1;
            streak  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= state == WAIT ? cnt + 3'd1 : 3'd1;
            if (state == IDLE && (if_req || d_req)) begin
                own_d   <= pick_d;
                is_wr   <= pick_d && d_we;
                addr_q  <= pick_d ? d_addr : if_addr;
                wdata_q <= pick_d ? d_wdata : '0;
                wstrb_q <= (pick_d && d_we) ? d_wstrb : '0;
                streak  <= (pick_d && if_req) ? streak + 1'b1 : '0;
            end
        end
    end
    assign mem_en    = state == ACCESS;
    assign mem_we    = mem_en ? wstrb_q : '0;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;
    assign if_gnt    = mem_en && !own_d;
    assign d_gnt     = mem_en && own_d;
    assign if_rvalid = done && !own_d;
    assign d_rvalid  = done && own_d;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
    assign busy      = state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level schedule model
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LAT = 2;
    localparam int MAXS = 3;
    logic clk = 0;
    logic reset = 0;
    logic if_req = 0, d_req = 0, d_we = 0;
    logic [AW-1:0] if_addr = 0, d_addr = 0, mem_addr;
    logic [DW-1:0] d_wdata = 0, mem_rdata = 0, if_rdata, d_rdata, mem_wdata;
    logic [3:0] d_wstrb = 0, mem_we;
    logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, busy;
    int tests = 0;
    int fails = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_DATA_STREAK(MAXS)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: gnt=%b/%b en=%b addr=%h busy=%b, want all 0", if_gnt, d_gnt, mem_en, mem_addr, busy);
        end
        reset = 0;
        idle_inputs();
        @(negedge clk);
        tests++;
        if (busy !== 0 || mem_en !== 0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b en=%b, want 0 0", busy, mem_en);
        end
    endtask

    task automatic test_fetch_read();
        do_reset();
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        tests++;
        if (if_gnt !== 1 || d_gnt !== 0 || mem_en !== 1 || mem_addr !== 32'h10 || mem_we !== 0 || busy !== 1) begin
            fails++;
            $display("FAIL fetch_grant: gnt=%b dgnt=%b en=%b addr=%h we=%b busy=%b, want 1 0 1 00000010 0 1", if_gnt, d_gnt, mem_en, mem_addr, mem_we, busy);
        end
        if_req = 0; if_addr = 0;
        @(negedge clk);
        tests++;
        if (if_rvalid !== 0 || if_rdata !== 0 || mem_en !== 0 || mem_addr !== 0 || busy !== 1) begin
            fails++;
            $display("FAIL fetch_wait: rvalid=%b rdata=%h en=%b addr=%h busy=%b, want 0 0 0 0 1", if_rvalid, if_rdata, mem_en, mem_addr, busy);
        end
        mem_rdata = 32'h13;
        @(negedge clk);
        tests++;
        if (if_rvalid !== 1 || if_rdata !== 32'h13 || d_rvalid !== 0 || d_rdata !== 0) begin
            fails++;
            $display("FAIL fetch_data: rvalid=%b rdata=%h drvalid=%b, want 1 00000013 0", if_rvalid, if_rdata, d_rvalid);
        end
        @(negedge clk);
        tests++;
        if (busy !== 0 || if_rvalid !== 0 || if_rdata !== 0) begin
            fails++;
            $display("FAIL fetch_done: busy=%b rvalid=%b rdata=%h, want 0 0 0", busy, if_rvalid, if_rdata);
        end
        mem_rdata = 0;
    endtask

    task automatic test_collision();
        int dg = -1, ig = -1, dv = -1;
        bit both = 0;
        do_reset();
        if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h100;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (if_gnt && d_gnt) both = 1;
            if (d_gnt && dg < 0) begin
                dg = k;
                tests++;
                if (mem_addr !== 32'h100) begin
                    fails++;
                    $display("FAIL collide_addr: addr=%h, want 00000100", mem_addr);
                end
                d_req = 0;
            end
            if (if_gnt && ig < 0) begin
                ig = k;
                if_req = 0;
            end
            if (d_rvalid && dv < 0) dv = k;
        end
        tests++;
        if (dg != 1 || ig != 5 || dv != 3 || both) begin
            fails++;
            $display("FAIL collide_order: dgnt@%0d ignt@%0d drvalid@%0d both=%0d, want 1 5 3 0", dg, ig, dv, both);
        end
    endtask

    task automatic test_streak();
        int n = 0;
        bit exp_f;
        do_reset();
        if_req = 1; if_addr = 32'h44; d_req = 1; d_we = 0; d_addr = 32'h200;
        for (int k = 0; k < 200 && n < 12; k++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) begin
                exp_f = (n % (MAXS + 1)) == MAXS;
                tests++;
                if (if_gnt !== exp_f || d_gnt !== !exp_f) begin
                    fails++;
                    $display("FAIL streak_grant%0d: ignt=%b dgnt=%b, want %b %b", n, if_gnt, d_gnt, exp_f, !exp_f);
                end
                n++;
            end
        end
        tests++;
        if (n != 12) begin
            fails++;
            $display("FAIL streak_timeout: saw %0d grants, want 12", n);
        end
        idle_inputs();
    endtask

    task automatic test_write(input logic [3:0] strb);
        bit rv = 0;
        do_reset();
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; d_wstrb = strb;
        @(negedge clk);
        tests++;
        if (d_gnt !== 1 || if_gnt !== 0 || mem_en !== 1 || mem_we !== strb || mem_addr !== 32'h20 || mem_wdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL write_access_%b: gnt=%b en=%b we=%b addr=%h wdata=%h, want 1 1 %b 00000020 deadbeef", strb, d_gnt, mem_en, mem_we, mem_addr, mem_wdata, strb);
        end
        idle_inputs();
        @(negedge clk);
        tests++;
        if (busy !== 0 || mem_en !== 0 || mem_we !== 0 || mem_wdata !== 0) begin
            fails++;
            $display("FAIL write_idle_%b: busy=%b en=%b we=%b wdata=%h, want 0 0 0 0", strb, busy, mem_en, mem_we, mem_wdata);
        end
        for (int k = 0; k < 4; k++) begin
            if (d_rvalid || if_rvalid) rv = 1;
            @(negedge clk);
        end
        tests++;
        if (rv) begin
            fails++;
            $display("FAIL write_rvalid_%b: rvalid seen after write, want none", strb);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        if_req = 1; if_addr = 32'h80;
        @(negedge clk);
        if_req = 0;
        @(negedge clk);
        mem_rdata = 32'hCAFEF00D;
        reset = 1; if_req = 1; if_addr = 32'h84;
        #1;
        tests++;
        if ({busy, if_gnt, if_rvalid, if_rdata, mem_en, mem_addr} !== '0) begin
            fails++;
            $display("FAIL midwait_async: busy=%b gnt=%b rvalid=%b en=%b addr=%h, want all 0", busy, if_gnt, if_rvalid, mem_en, mem_addr);
        end
        @(negedge clk);
        tests++;
        if (if_rvalid !== 0 || if_rdata !== 0) begin
            fails++;
            $display("FAIL midwait_drop: rvalid=%b rdata=%h, want 0 0", if_rvalid, if_rdata);
        end
        reset = 0;
        @(negedge clk);
        tests++;
        if (if_gnt !== 1 || mem_addr !== 32'h84) begin
            fails++;
            $display("FAIL midwait_regrant: gnt=%b addr=%h, want 1 00000084", if_gnt, mem_addr);
        end
        idle_inputs();
    endtask

    // the model schedules each accepted transaction as absolute cycle numbers: grant, read return, port free
    task automatic test_random();
        int free_at = 0, gnt_at = -1, rv_at = -1, streak_m = 0;
        bit gnt_d = 0, rv_d = 0, e_wr = 0, win_d;
        logic e_ig, e_dg, e_iv, e_dv, e_en;
        logic [3:0] e_we = 0;
        logic [AW-1:0] e_addr = 0;
        logic [DW-1:0] e_wdata = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            e_ig = c == gnt_at && !gnt_d;
            e_dg = c == gnt_at && gnt_d;
            e_iv = c == rv_at && !rv_d;
            e_dv = c == rv_at && rv_d;
            e_en = c == gnt_at;
            tests++;
            if ({if_gnt, d_gnt} !== {e_ig, e_dg}) begin
                fails++;
                $display("FAIL rnd_gnt c%0d: if/d=%b%b, want %b%b", c, if_gnt, d_gnt, e_ig, e_dg);
            end
            tests++;
            if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== {e_iv, e_dv, e_iv ? mem_rdata : 32'h0, e_dv ? mem_rdata : 32'h0}) begin
                fails++;
                $display("FAIL rnd_rdata c%0d: rv=%b%b rdata=%h/%h, want %b%b mem_rdata=%h", c, if_rvalid, d_rvalid, if_rdata, d_rdata, e_iv, e_dv, mem_rdata);
            end
            tests++;
            if ({mem_en, mem_we, mem_addr} !== {e_en, e_en ? e_we : 4'h0, e_en ? e_addr : 32'h0}) begin
                fails++;
                $display("FAIL rnd_mem c%0d: en=%b we=%b addr=%h, want %b %b %h", c, mem_en, mem_we, mem_addr, e_en, e_en ? e_we : 4'h0, e_en ? e_addr : 32'h0);
            end
            if (!e_en || e_wr) begin
                tests++;
                if (mem_wdata !== (e_en ? e_wdata : 32'h0)) begin
                    fails++;
                    $display("FAIL rnd_wdata c%0d: wdata=%h, want %h", c, mem_wdata, e_en ? e_wdata : 32'h0);
                end
            end
            tests++;
            if (busy !== (c < free_at)) begin
                fails++;
                $display("FAIL rnd_busy c%0d: busy=%b, want %b", c, busy, c < free_at);
            end
            if (c == gnt_at) begin
                if (gnt_d) d_req = 0;
                else if_req = 0;
            end
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = $urandom_range(0, 1) == 1; d_addr = $urandom; d_wdata = $urandom;
                d_wstrb = $urandom_range(0, 3) == 0 ? 4'h0 : 4'($urandom);
            end
            mem_rdata = $urandom;
            if (c >= free_at && (if_req || d_req)) begin
                win_d = d_req && !(if_req && streak_m == MAXS);
                streak_m = (win_d && if_req) ? streak_m + 1 : 0;
                gnt_at = c + 1;
                gnt_d = win_d;
                e_wr = win_d && d_we;
                e_addr = win_d ? d_addr : if_addr;
                e_we = e_wr ? d_wstrb : 4'h0;
                e_wdata = d_wdata;
                if (e_wr) free_at = c + 2;
                else begin
                    rv_at = c + 1 + LAT;
                    rv_d = win_d;
                    free_at = c + 2 + LAT;
                end
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_collision();
        test_streak();
        test_write(4'b0011);
        test_write(4'b0000);
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
